// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial
// Brief    : Slice-serial ALU (AND/OR/XOR/ADD/SUB/SLT), SLICE bits per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int STEPS = WIDTH / SLICE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  generate
    if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
      $error("alu_serial: WIDTH must be >= 2 and an integer multiple of SLICE");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  // Slice datapath: operands are shifted right each step, so bits [SLICE-1:0]
  // always hold the current slice.
  logic             b_inv;
  logic             c_chain;
  logic             c_msb_in;
  logic [SLICE-1:0] slice_arith;
  logic [SLICE-1:0] slice_logic;
  logic [SLICE-1:0] slice_res;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    b_inv       = (op_q == OP_SUB) || (op_q == OP_SLT);
    c_chain     = carry_q;
    c_msb_in    = 1'b0;
    slice_arith = '0;
    slice_logic = '0;
    for (int i = 0; i < SLICE; i++) begin
      c_msb_in       = c_chain;
      slice_arith[i] = a_q[i] ^ (b_q[i] ^ b_inv) ^ c_chain;
      c_chain        = (a_q[i] & (b_q[i] ^ b_inv)) | (c_chain & (a_q[i] ^ (b_q[i] ^ b_inv)));
    end
    case (op_q)
      OP_AND:  slice_logic = a_q[SLICE-1:0] & b_q[SLICE-1:0];
      OP_OR:   slice_logic = a_q[SLICE-1:0] | b_q[SLICE-1:0];
      OP_XOR:  slice_logic = a_q[SLICE-1:0] ^ b_q[SLICE-1:0];
      default: slice_logic = '0;
    endcase
    case (op_q)
      OP_ADD, OP_SUB, OP_SLT: slice_res = slice_arith;
      default:                slice_res = slice_logic;
    endcase
    // New slice enters at the top so the LSB slice lands at bit 0 after STEPS.
    acc_next = (acc_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
  end

  logic [WIDTH-1:0] fin_result;
  logic             fin_carry;
  logic             fin_ovf;

  always_comb begin
    fin_result = '0;
    fin_carry  = 1'b0;
    fin_ovf    = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        fin_result = acc_next;
        fin_carry  = c_chain;
        fin_ovf    = c_msb_in ^ c_chain;
      end
      OP_SLT: begin
        fin_result = WIDTH'(acc_next[WIDTH-1] ^ (c_msb_in ^ c_chain));
        fin_carry  = c_chain;
      end
      OP_AND, OP_OR, OP_XOR: begin
        fin_result = acc_next;
      end
      default: begin
        fin_result = '0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    step_d      = step_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          op_d    = alu_op;
          step_d  = '0;
          carry_d = (alu_op == OP_SUB) || (alu_op == OP_SLT);
          acc_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        carry_d = c_chain;
        acc_d   = acc_next;
        step_d  = step_q + CNT_W'(1);
        if (step_q == LAST_STEP) begin
          state_d     = S_DONE;
          result_d    = fin_result;
          carry_out_d = fin_carry;
          overflow_d  = fin_ovf;
          zero_d      = (fin_result == '0);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      step_q      <= '0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      step_q      <= step_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_serial
// Brief    : Directed, table-driven bench for alu_serial in three geometries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_r [3];
  logic [31:0] a_r     [3];
  logic [31:0] b_r     [3];
  logic [2:0]  op_r    [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic        co_w    [3];
  logic        ov_w    [3];
  logic        z_w     [3];
  logic [31:0] res_w   [3];
  logic [7:0]  res0, res1;
  logic [31:0] res2;

  int steps [3] = '{8, 2, 4};
  int tests = 0;
  int fails = 0;

  alu_serial #(.WIDTH(8), .SLICE(1)) u_w8s1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .a(a_r[0][7:0]), .b(b_r[0][7:0]),
    .alu_op(op_r[0]), .busy(busy_w[0]), .done(done_w[0]), .result(res0),
    .carry_out(co_w[0]), .overflow(ov_w[0]), .zero(z_w[0])
  );
  alu_serial #(.WIDTH(8), .SLICE(4)) u_w8s4 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .a(a_r[1][7:0]), .b(b_r[1][7:0]),
    .alu_op(op_r[1]), .busy(busy_w[1]), .done(done_w[1]), .result(res1),
    .carry_out(co_w[1]), .overflow(ov_w[1]), .zero(z_w[1])
  );
  alu_serial #(.WIDTH(32), .SLICE(8)) u_w32s8 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .a(a_r[2]), .b(b_r[2]),
    .alu_op(op_r[2]), .busy(busy_w[2]), .done(done_w[2]), .result(res2),
    .carry_out(co_w[2]), .overflow(ov_w[2]), .zero(z_w[2])
  );
  assign res_w[0] = {24'h0, res0};
  assign res_w[1] = {24'h0, res1};
  assign res_w[2] = res2;

  typedef struct {
    int          cfg;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives a request from just after an edge; the next rising edge accepts it.
  task automatic do_start(input int c, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_r[c] = 1'b1;
    a_r[c]     = a;
    b_r[c]     = b;
    op_r[c]    = op;
    @(posedge clk);
    #1;
    start_r[c] = 1'b0;
  endtask

  task automatic wait_done(input int c, input int exp_cycles, input string name);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1'b1;
    while (n < exp_cycles + 4) begin
      if (busy_w[c] !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (done_w[c] === 1'b1) break;
    end
    chk({name, " latency"}, 32'(n), 32'(exp_cycles));
    chk({name, " busy in RUN"}, 32'(busy_ok), 32'd1);
    chk({name, " busy in DONE"}, 32'(busy_w[c]), 32'd0);
  endtask

  task automatic check_out(input int c, input string name, input logic [31:0] res,
                           input logic co, input logic ov);
    chk({name, " result"}, res_w[c], res);
    chk({name, " carry_out"}, 32'(co_w[c]), 32'(co));
    chk({name, " overflow"}, 32'(ov_w[c]), 32'(ov));
    chk({name, " zero"}, 32'(z_w[c]), 32'(res == 32'h0));
  endtask

  initial begin
    int done_seen;
    string nm;

    // cfg: 0 = W8/S1, 1 = W8/S4, 2 = W32/S8
    vecs.push_back('{0, 3'b010, 32'hFF,       32'h01,       32'h00,       1'b1, 1'b0});
    vecs.push_back('{0, 3'b110, 32'h80,       32'h01,       32'h7F,       1'b1, 1'b1});
    vecs.push_back('{0, 3'b111, 32'h80,       32'h01,       32'h01,       1'b1, 1'b0});
    vecs.push_back('{0, 3'b000, 32'hF0,       32'h3C,       32'h30,       1'b0, 1'b0});
    vecs.push_back('{0, 3'b001, 32'h12,       32'h21,       32'h33,       1'b0, 1'b0});
    vecs.push_back('{0, 3'b011, 32'hFF,       32'hFF,       32'h00,       1'b0, 1'b0});
    vecs.push_back('{0, 3'b010, 32'h7F,       32'h01,       32'h80,       1'b0, 1'b1});
    vecs.push_back('{0, 3'b110, 32'h05,       32'h07,       32'hFE,       1'b0, 1'b0});
    vecs.push_back('{0, 3'b111, 32'h05,       32'h07,       32'h01,       1'b0, 1'b0});
    vecs.push_back('{0, 3'b111, 32'h07,       32'h05,       32'h00,       1'b1, 1'b0});
    vecs.push_back('{0, 3'b100, 32'hFF,       32'hFF,       32'h00,       1'b0, 1'b0});
    vecs.push_back('{0, 3'b101, 32'hAA,       32'h55,       32'h00,       1'b0, 1'b0});
    vecs.push_back('{1, 3'b010, 32'h0F,       32'h01,       32'h10,       1'b0, 1'b0});
    vecs.push_back('{1, 3'b110, 32'h10,       32'h01,       32'h0F,       1'b1, 1'b0});
    vecs.push_back('{1, 3'b100, 32'hFF,       32'hFF,       32'h00,       1'b0, 1'b0});
    vecs.push_back('{2, 3'b110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{2, 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0});
    vecs.push_back('{2, 3'b000, 32'hDEADBEEF, 32'h0F0F0F0F, 32'h0E0D0E0F, 1'b0, 1'b0});

    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      start_r[c] = 1'b0;
      a_r[c]     = '0;
      b_r[c]     = '0;
      op_r[c]    = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      nm = $sformatf("reset cfg%0d", c);
      chk({nm, " busy"}, 32'(busy_w[c]), 32'd0);
      chk({nm, " done"}, 32'(done_w[c]), 32'd0);
      chk({nm, " result"}, res_w[c], 32'h0);
      chk({nm, " carry/ovf/zero"}, {29'h0, co_w[c], ov_w[c], z_w[c]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      nm = $sformatf("vec%0d cfg%0d op%0b", i, vecs[i].cfg, vecs[i].op);
      do_start(vecs[i].cfg, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].cfg, steps[vecs[i].cfg], nm);
      check_out(vecs[i].cfg, nm, vecs[i].res, vecs[i].co, vecs[i].ov);
      @(posedge clk);
      #1;
      chk({nm, " done one-shot"}, 32'(done_w[vecs[i].cfg]), 32'd0);
      chk({nm, " result held"}, res_w[vecs[i].cfg], vecs[i].res);
    end

    // start during RUN must not disturb the running ADD
    do_start(0, 3'b010, 32'h12, 32'h34);
    @(posedge clk);
    #1;
    start_r[0] = 1'b1; a_r[0] = 32'hFF; b_r[0] = 32'hFF; op_r[0] = 3'b001;
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    wait_done(0, 6, "ignore-start w8s1");
    check_out(0, "ignore-start w8s1", 32'h46, 1'b0, 1'b0);

    do_start(1, 3'b011, 32'hA5, 32'h0F);
    start_r[1] = 1'b1; a_r[1] = 32'h00; b_r[1] = 32'h00; op_r[1] = 3'b010;
    @(posedge clk);
    #1;
    start_r[1] = 1'b0;
    wait_done(1, 1, "ignore-start w8s4 xor");
    check_out(1, "ignore-start w8s4 xor", 32'hAA, 1'b0, 1'b0);

    // back-to-back: new start issued in the DONE cycle
    do_start(2, 3'b010, 32'h7FFFFFFF, 32'h00000001);
    wait_done(2, 4, "b2b add w32s8");
    check_out(2, "b2b add w32s8", 32'h80000000, 1'b0, 1'b1);
    do_start(2, 3'b001, 32'hF0F0F0F0, 32'h0F0F0F0F);
    chk("b2b no idle busy", 32'(busy_w[2]), 32'd1);
    chk("b2b result held during RUN", res_w[2], 32'h80000000);
    wait_done(2, 4, "b2b or w32s8");
    check_out(2, "b2b or w32s8", 32'hFFFFFFFF, 1'b0, 1'b0);

    // asynchronous reset in the middle of a RUN
    do_start(0, 3'b110, 32'h80, 32'h01);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun reset busy", 32'(busy_w[0]), 32'd0);
    chk("midrun reset done", 32'(done_w[0]), 32'd0);
    chk("midrun reset result", res_w[0], 32'h0);
    chk("midrun reset flags", {29'h0, co_w[0], ov_w[0], z_w[0]}, 32'h0);
    chk("midrun reset other dut result", res_w[2], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_w[0] === 1'b1) done_seen++;
    end
    chk("aborted op never done", 32'(done_seen), 32'd0);
    do_start(0, 3'b010, 32'h7F, 32'h01);
    wait_done(0, 8, "post-reset add");
    check_out(0, "post-reset add", 32'h80, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
